key_ctrl: RTL and testbench

- Keypad front-end controller for the 16-key hex pad on the board.
- Synchronises and debounces the raw keys, then priority-encodes them: keys[15] is code 0x0 and keys[0] is code 0xF; the highest bit wins.
- Emits exactly one strobe per accepted press and shifts the code into a 32-bit hex entry register used for manual data/address entry.
- Sits between the keypad pins and the front-panel/register-load logic.

---
 rtl/key_pkg.sv | 26 ++
 rtl/key_sync.sv | 30 +++
 rtl/key_ctrl.sv | 157 +++++++++++++++
 tb/tb_key_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the keypad front-end.
//   key_state_e  : debounce/press FSM states
//   ENTRY_DIGITS : number of hex digits held by the entry register
//   prio_enc()   : 16-key priority encoder, keys[15] -> 0x0 ... keys[0] -> 0xF
package key_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    PRESSED  = 2'd2,
    DB_REL   = 2'd3
  } key_state_e;

  localparam int unsigned ENTRY_DIGITS = 8;

  // Highest set bit wins; ascending scan lets higher bits overwrite lower ones.
  function automatic logic [3:0] prio_enc(input logic [15:0] v);
    logic [3:0] code;
    code = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i]) code = 4'(15 - i);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for asynchronous key lines.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   d_i    : raw asynchronous inputs
//   q_o    : synchronised outputs
module key_sync #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_ctrl.sv
// Keypad front-end: synchronise, debounce and priority-encode a 16-key hex
// pad, emit one strobe per accepted press and shift the code into a 32-bit
// hex entry register.
//   clock      : system clock, rising edge
//   reset      : asynchronous active-low reset
//   keys       : raw key lines, 1 = pressed
//   clear      : synchronous clear of entry/ndigits (wins over same-cycle accept)
//   key_strobe : one-cycle pulse per accepted press
//   key_code   : code of last accepted key
//   key_down   : accepted key still held (PRESSED or DB_REL)
//   entry      : hex entry register, newest digit in [3:0]
//   ndigits    : digits entered since clear, saturating at ENTRY_DIGITS
module key_ctrl
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] keys,
  input  logic        clear,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [31:0] entry,
  output logic [3:0]  ndigits
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       ND_MAX   = 4'(ENTRY_DIGITS);

  logic [15:0] s;
  logic        any_s;
  logic [3:0]  code_s;

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             accept;

  logic        strobe_q, strobe_d;
  logic [3:0]  code_q, code_d;
  logic        down_q, down_d;
  logic [31:0] entry_q, entry_d;
  logic [3:0]  nd_q, nd_d;

  key_sync #(.W(16)) u_sync (
    .clk_i  (clock),
    .rst_ni (reset),
    .d_i    (keys),
    .q_o    (s)
  );

  assign any_s  = |s;
  assign code_s = prio_enc(s);

  // State register plus debounce bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_s) begin
          state_d = DB_PRESS;
          cand_d  = code_s;
          cnt_d   = CNT_ONE;
        end
      end
      DB_PRESS: begin
        if (!any_s) begin
          state_d = IDLE;
        end else if (code_s != cand_q) begin
          cand_d = code_s;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!any_s) begin
          state_d = DB_REL;
          cnt_d   = CNT_ONE;
        end
      end
      DB_REL: begin
        if (any_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; key_down follows the next state so it is registered
  // yet aligned with the state register.
  always_comb begin
    strobe_d = accept;
    code_d   = accept ? cand_q : code_q;
    down_d   = (state_d == PRESSED) || (state_d == DB_REL);
    entry_d  = entry_q;
    nd_d     = nd_q;
    if (clear) begin
      entry_d = '0;
      nd_d    = '0;
    end else if (accept) begin
      entry_d = {entry_q[27:0], cand_q};
      if (nd_q < ND_MAX) nd_d = nd_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      strobe_q <= 1'b0;
      code_q   <= '0;
      down_q   <= 1'b0;
      entry_q  <= '0;
      nd_q     <= '0;
    end else begin
      strobe_q <= strobe_d;
      code_q   <= code_d;
      down_q   <= down_d;
      entry_q  <= entry_d;
      nd_q     <= nd_d;
    end
  end

  assign key_strobe = strobe_q;
  assign key_code   = code_q;
  assign key_down   = down_q;
  assign entry      = entry_q;
  assign ndigits    = nd_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Self-checking bench for key_ctrl with DEBOUNCE_CYCLES=4.
module tb_key_ctrl;

  localparam int unsigned DB = 4;

  logic        clock;
  logic        reset;
  logic [15:0] keys;
  logic        clear;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic        key_down;
  logic [31:0] entry;
  logic [3:0]  ndigits;

  key_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .keys       (keys),
    .clear      (clear),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .key_down   (key_down),
    .entry      (entry),
    .ndigits    (ndigits)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int nstrobes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Run-length view of the synchronised samples: a press is accepted after
  // DB identical non-zero samples while not held; held ends after DB zeros.
  typedef struct {
    logic [3:0]  code;
    logic [31:0] entry;
    logic [3:0]  nd;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] d1, d2, seen;
  int          run, zero_run;
  logic [3:0]  run_code, last_code, c_m;
  bit          held, acc;
  logic [3:0]  digits[$];

  function automatic logic [3:0] enc_ref(input logic [15:0] v);
    for (int b = 15; b >= 0; b--) if (v[b]) return 4'(15 - b);
    return 4'd0;
  endfunction

  function automatic logic [31:0] entry_ref();
    logic [31:0] e;
    e = 0;
    foreach (digits[i]) e = e * 16 + 32'(digits[i]);
    return e;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      d1 = 0; d2 = 0; run = 0; zero_run = 0; run_code = 0;
      last_code = 0; held = 0;
      digits.delete();
      expq.delete();
    end else begin
      seen = d2;   // FSM sees keys from two edges earlier
      d2 = d1;
      d1 = keys;
      acc = 0;
      c_m = 0;
      if (seen != 0) begin
        zero_run = 0;
        c_m = enc_ref(seen);
        if (!held) begin
          if (run > 0 && c_m == run_code) run++;
          else begin run = 1; run_code = c_m; end
          if (run == DB) begin acc = 1; held = 1; end
        end
      end else begin
        run = 0;
        if (held) begin
          zero_run++;
          if (zero_run == DB) begin held = 0; zero_run = 0; end
        end
      end
      if (clear) digits.delete();
      else if (acc) begin
        digits.push_back(c_m);
        if (digits.size() > 8) void'(digits.pop_front());
      end
      if (acc) begin
        last_code = c_m;
        expq.push_back('{code: c_m, entry: entry_ref(), nd: 4'(digits.size())});
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      if (key_strobe) begin
        nstrobes++;
        if (expq.size() == 0) chk("unexpected_strobe", 32'(key_strobe), 32'd0);
        else begin
          exp_t e;
          e = expq.pop_front();
          chk("strobe_code", 32'(key_code), 32'(e.code));
          chk("strobe_entry", entry, e.entry);
          chk("strobe_ndigits", 32'(ndigits), 32'(e.nd));
        end
      end else begin
        chk("missed_strobe", 32'(expq.size()), 32'd0);
      end
      chk("key_down", 32'(key_down), 32'(held));
      chk("key_code_hold", 32'(key_code), 32'(last_code));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic hold(input logic [15:0] k, input int n);
    keys = k;
    cyc(n);
  endtask

  task automatic press(input logic [15:0] k);
    hold(k, DB + 4);
    hold(16'h0000, DB + 4);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  int          s0;
  logic [15:0] pat, prev;
  int          len;

  initial begin
    reset = 1'b0;
    keys  = '0;
    clear = 1'b0;
    #1;
    chk("reset_strobe", 32'(key_strobe), 32'd0);
    chk("reset_entry", entry, 32'd0);
    chk("reset_ndigits", 32'(ndigits), 32'd0);
    chk("reset_key_down", 32'(key_down), 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(1);

    // 1: single press, latency and accept actions
    s0 = nstrobes;
    hold(16'h0800, DB + 4);
    chk("t1_code", 32'(key_code), 32'h4);
    chk("t1_entry", entry, 32'h0000_0004);
    chk("t1_ndigits", 32'(ndigits), 32'd1);
    chk("t1_down_held", 32'(key_down), 32'd1);
    hold(16'h0000, DB + 4);
    chk("t1_down_released", 32'(key_down), 32'd0);
    chk("t1_strobes", 32'(nstrobes - s0), 32'd1);

    // 2: press bounce, then a stable press
    s0 = nstrobes;
    hold(16'h0800, 2);
    hold(16'h0000, 1);
    hold(16'h0800, 2);
    hold(16'h0000, DB + 4);
    chk("t2_bounce_no_strobe", 32'(nstrobes - s0), 32'd0);
    press(16'h0800);
    chk("t2_strobes", 32'(nstrobes - s0), 32'd1);
    chk("t2_entry", entry, 32'h0000_0044);

    // 3: nine digits, saturation
    pulse_clear();
    for (int c = 1; c <= 9; c++) press(16'h0001 << (15 - c));
    chk("t3_entry", entry, 32'h2345_6789);
    chk("t3_ndigits", 32'(ndigits), 32'd8);

    // 4: multi-key priority, no rollover
    s0 = nstrobes;
    hold(16'h8001, DB + 4);
    chk("t4_code_prio", 32'(key_code), 32'h0);
    hold(16'h0001, DB + 4);
    chk("t4_no_rollover", 32'(nstrobes - s0), 32'd1);
    hold(16'h0000, DB + 4);
    hold(16'h0001, DB + 4);
    chk("t4_code_f", 32'(key_code), 32'hF);
    hold(16'h0000, DB + 4);

    // 5: release bounce
    s0 = nstrobes;
    hold(16'h0800, DB + 4);
    hold(16'h0000, 2);
    hold(16'h0800, DB + 4);
    chk("t5_down", 32'(key_down), 32'd1);
    chk("t5_strobes", 32'(nstrobes - s0), 32'd1);
    hold(16'h0000, DB + 4);

    // 6: clear on accept edge, then reset mid-debounce
    pulse_clear();
    press(16'h4000);
    press(16'h2000);
    chk("t6_entry_pre", entry, 32'h0000_0012);
    keys = 16'h0020;          // code 0xA
    cyc(DB + 1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("t6_strobe", 32'(key_strobe), 32'd1);
    chk("t6_code", 32'(key_code), 32'hA);
    chk("t6_entry", entry, 32'd0);
    chk("t6_ndigits", 32'(ndigits), 32'd0);
    hold(16'h0000, DB + 4);
    press(16'h0100);
    s0 = nstrobes;
    keys = 16'h0800;
    cyc(4);
    reset = 1'b0;
    #1;
    chk("t6_rst_strobe", 32'(key_strobe), 32'd0);
    chk("t6_rst_code", 32'(key_code), 32'd0);
    chk("t6_rst_down", 32'(key_down), 32'd0);
    chk("t6_rst_entry", entry, 32'd0);
    chk("t6_rst_ndigits", 32'(ndigits), 32'd0);
    keys = 16'h0000;
    cyc(2);
    reset = 1'b1;
    cyc(DB + 4);
    chk("t6_rst_no_strobe", 32'(nstrobes - s0), 32'd0);

    // Random traffic
    prev = 16'h0800;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: pat = 16'h0000;
        3, 4:    pat = prev;
        5, 6:    pat = 16'h0001 << $urandom_range(0, 15);
        7:       pat = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        default: pat = 16'($urandom);
      endcase
      if (pat != 0) prev = pat;
      len = int'($urandom_range(1, DB + 5));
      clear = ($urandom_range(0, 15) == 0);
      keys = pat;
      cyc(1);
      clear = 1'b0;
      if (len > 1) cyc(len - 1);
    end
    hold(16'h0000, DB + 4);
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
